// File: rtl/regfile_pkg.sv
// Shared types and sizing for the 8 x 16 register file.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int NUM_RD   = 2;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_word_t data;
    } wr_req_t;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side signals of the register file.
interface register_file_if;
    import regfile_pkg::*;

    logic      write;
    reg_addr_t wreg;
    reg_addr_t rreg1;
    reg_addr_t rreg2;
    reg_word_t wd;
    reg_word_t rd1;
    reg_word_t rd2;

    modport master (output write, wreg, rreg1, rreg2, wd, input rd1, rd2);
    modport slave  (input write, wreg, rreg1, rreg2, wd, output rd1, rd2);

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read mux; REGFILE_BYPASS_EN adds same-cycle write forwarding.
module regfile_read_port
    import regfile_pkg::*;
(
    input  reg_word_t [NUM_REGS-1:0] regs_i,
    input  reg_addr_t                raddr_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                     byp_en_i,
    input  reg_addr_t                waddr_i,
    input  reg_word_t                wdata_i,
`endif
    output reg_word_t                rdata_o
);

    always_comb begin
        rdata_o = regs_i[raddr_i];
`ifdef REGFILE_BYPASS_EN
        // byp_en_i already folds in reset, so reset suppresses forwarding
        if (byp_en_i && (raddr_i == waddr_i))
            rdata_o = wdata_i;
`endif
    end

endmodule

// File: rtl/register_file.sv
// 8 x 16 register file: one synchronous write port, two combinational read ports.
// Optional write-through forwarding under REGFILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    register_file_if.slave rf
);

    reg_word_t [NUM_REGS-1:0] regs_q, regs_d;
    wr_req_t                  wr_req;
    reg_addr_t [NUM_RD-1:0]   rd_addr;
    reg_word_t [NUM_RD-1:0]   rd_data;

    assign wr_req = '{en: rf.write, addr: rf.wreg, data: rf.wd};

    always_comb begin
        regs_d = regs_q;
        if (wr_req.en)
            regs_d[wr_req.addr] = wr_req.data;
    end

    // Reset wins over a write presented in the same cycle
    always_ff @(posedge clock) begin
        if (!reset)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    assign rd_addr = {rf.rreg2, rf.rreg1};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port u_rd (
            .regs_i   (regs_q),
            .raddr_i  (rd_addr[p]),
`ifdef REGFILE_BYPASS_EN
            .byp_en_i (wr_req.en & reset),
            .waddr_i  (wr_req.addr),
            .wdata_i  (wr_req.data),
`endif
            .rdata_o  (rd_data[p])
        );
    end

    assign rf.rd1 = rd_data[0];
    assign rf.rd2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_register_file;
    import regfile_pkg::*;

    logic clock;
    logic reset;
    register_file_if rf();

    register_file dut (.clock(clock), .reset(reset), .rf(rf));

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct packed {
        reg_word_t rd1;
        reg_word_t rd2;
    } exp_t;

    exp_t      exp_q[$];
    string     name_q[$];
    reg_word_t model [NUM_REGS];
    int        checks = 0;
    int        errors = 0;

    function automatic reg_word_t ref_read(reg_addr_t a);
`ifdef REGFILE_BYPASS_EN
        if (reset && rf.write && a == rf.wreg) return rf.wd;
`endif
        return model[a];
    endfunction

    // Drive one cycle; optionally queue the expected reads; then advance the model.
    task automatic step(input logic rst, input logic wr, input reg_addr_t wa,
                        input reg_word_t d, input reg_addr_t r1, input reg_addr_t r2,
                        input bit chk, input string name);
        reset    = rst;
        rf.write = wr;
        rf.wreg  = wa;
        rf.wd    = d;
        rf.rreg1 = r1;
        rf.rreg2 = r2;
        if (chk) begin
            exp_q.push_back('{rd1: ref_read(r1), rd2: ref_read(r2)});
            name_q.push_back(name);
        end
        @(posedge clock);
        if (!rst) begin
            foreach (model[i]) model[i] = '0;
        end else if (wr) begin
            model[wa] = d;
        end
        #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (rf.rd1 !== e.rd1) begin
                errors++;
                $display("FAIL %s rd1: got %h expected %h (rreg1=%0d)", n, rf.rd1, e.rd1, rf.rreg1);
            end
            checks++;
            if (rf.rd2 !== e.rd2) begin
                errors++;
                $display("FAIL %s rd2: got %h expected %h (rreg2=%0d)", n, rf.rd2, e.rd2, rf.rreg2);
            end
        end
    end

    initial begin
        reg_word_t rw;
        foreach (model[i]) model[i] = 'x;
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, "init");

        for (int i = 0; i < NUM_REGS; i++)
            step(1'b1, 1'b0, 3'd0, 16'h0, 3'(i), 3'(NUM_REGS-1-i), 1'b1, "reset_sweep");

        step(1'b1, 1'b1, 3'd3, 16'hAAAA, 3'd0, 3'd1, 1'b0, "wr3");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd4, 1'b1, "rd_port1");
        step(1'b1, 1'b1, 3'd5, 16'h5555, 3'd3, 3'd0, 1'b0, "wr5");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b1, "rd_port2");
        step(1'b1, 1'b0, 3'd3, 16'h1234, 3'd3, 3'd3, 1'b1, "we_gate_pre");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b1, "we_gate");
        step(1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd5, 1'b1, "reset_vs_write_pre");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd5, 1'b1, "reset_beats_write");
        step(1'b1, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd2, 1'b1, "rdw_same_cycle");
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b1, "rdw_after");

        for (int k = 0; k < 400; k++) begin
            rw = 16'($urandom);
            step(($urandom_range(0, 24) != 0), 1'($urandom), 3'($urandom), rw,
                 3'($urandom), 3'($urandom), 1'b1, "random");
        end

        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, "drain");
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
